// File: rtl/ifetch_32.sv
// Instruction fetch stage: owns the PC, issues word-aligned reads to instruction memory and
// buffers in-order responses as {pc, instruction} for the decoder, with branch redirect/flush.
module ifetch_32 #(
  parameter int unsigned           REG_WIDTH  = 32,
  parameter logic [REG_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_imem_valid,
  output logic [REG_WIDTH-1:0] o_imem_addr,
  input  logic                 i_imem_ready,
  input  logic                 i_imem_rvalid,
  input  logic [REG_WIDTH-1:0] i_imem_rdata,
  input  logic                 i_redirect,
  input  logic [REG_WIDTH-1:0] i_redirect_pc,
  output logic                 o_valid,
  output logic [REG_WIDTH-1:0] o_instruction,
  output logic [REG_WIDTH-1:0] o_pc,
  input  logic                 i_ready
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CntW:0]      CreditMax = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW-1:0]    PtrLast   = PtrW'(FIFO_DEPTH - 1);
  localparam logic [REG_WIDTH-1:0] PcStep  = REG_WIDTH'(4);
  localparam logic [REG_WIDTH-1:0] AlignMask = ~REG_WIDTH'(3);

  logic [REG_WIDTH-1:0] pc_q, pc_d;
  logic [REG_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]      outstanding_q, outstanding_d;
  logic [CntW-1:0]      discard_q, discard_d;
  logic [CntW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;

  logic [REG_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [REG_WIDTH-1:0] fifo_instr_q [FIFO_DEPTH];

  logic                 credit_ok;
  logic                 imem_valid;
  logic                 accept;
  logic                 rsp_take;
  logic                 rsp_drop;
  logic                 push;
  logic                 out_valid;
  logic                 pop;
  logic [REG_WIDTH-1:0] target_pc;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // Credit counts both in-flight requests and buffered entries, so a push can never overflow.
  assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, fifo_cnt_q}) < CreditMax;
  assign imem_valid = !i_rst && !i_redirect && credit_ok;
  assign accept     = imem_valid && i_imem_ready;

  // A response with nothing outstanding is a stale beat from before reset; ignore it.
  assign rsp_take   = !i_rst && i_imem_rvalid && (outstanding_q != '0);
  assign rsp_drop   = rsp_take && ((discard_q != '0) || i_redirect);
  assign push       = rsp_take && !rsp_drop;

  assign out_valid  = !i_rst && !i_redirect && (fifo_cnt_q != '0);
  assign pop        = out_valid && i_ready;

  assign target_pc  = i_redirect_pc & AlignMask;

  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CntW'(accept) - CntW'(rsp_take);
    discard_d     = discard_q;
    fifo_cnt_d    = fifo_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (i_redirect) begin
      pc_d       = target_pc;
      rsp_pc_d   = target_pc;
      // Every request still in flight after this cycle belongs to the wrong path.
      discard_d  = outstanding_q - CntW'(rsp_take);
      fifo_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (accept) begin
        pc_d = pc_q + PcStep;
      end
      if (rsp_drop) begin
        discard_d = discard_q - 1'b1;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + PcStep;
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      fifo_cnt_d = fifo_cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Buffer storage needs no reset: fifo_cnt_q qualifies every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
      fifo_instr_q[wr_ptr_q] <= i_imem_rdata;
    end
  end

  assign o_imem_valid  = imem_valid;
  assign o_imem_addr   = pc_q;
  assign o_valid       = out_valid;
  assign o_pc          = fifo_pc_q[rd_ptr_q];
  assign o_instruction = fifo_instr_q[rd_ptr_q];

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_imem_rvalid) begin
      assert (outstanding_q != '0);
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_32.sv
// Randomized bench for ifetch_32: a queue-based reference model of in-flight requests and
// buffered instructions predicts every output each cycle; a small memory model answers requests.
module tb_ifetch_32;

  localparam int unsigned Depth   = 2;
  localparam logic [31:0] ResetPc = 32'h0;

  logic        i_clk;
  logic        i_rst;
  logic        o_imem_valid;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        i_ready;

  ifetch_32 #(
    .REG_WIDTH  (32),
    .RESET_PC   (ResetPc),
    .FIFO_DEPTH (Depth)
  ) u_dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_imem_valid  (o_imem_valid),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_rvalid (i_imem_rvalid),
    .i_imem_rdata  (i_imem_rdata),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_valid       (o_valid),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .i_ready       (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        keep;
  } infl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  infl_t       infl_q[$];
  ent_t        fifo_m[$];
  logic [31:0] m_pc;

  int unsigned mem_due[$];
  int unsigned last_due;
  int unsigned cyc;
  bit          prev_rst;

  int unsigned ready_pct;
  int unsigned mready_mode;  // 0 always ready, 1 toggling 1010, 2 random
  int unsigned max_lat;

  int n_cmp;
  int n_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %08h expected %08h", tag, cyc, obs, exp);
    end
  endtask

  task automatic run_cycle(input bit rst, input bit redir, input logic [31:0] rpc);
    bit          exp_iv;
    bit          exp_v;
    infl_t       e;
    int unsigned due;
    @(negedge i_clk);
    i_rst         = rst;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_ready       = ($urandom_range(99) < ready_pct);
    case (mready_mode)
      0:       i_imem_ready = 1'b1;
      1:       i_imem_ready = (cyc % 2 == 0);
      default: i_imem_ready = $urandom_range(1);
    endcase
    // Memory is reset with the core: stale beats may only land while reset is held.
    if (!rst && prev_rst) begin
      mem_due.delete();
      last_due = 0;
    end
    if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
      void'(mem_due.pop_front());
      i_imem_rvalid = 1'b1;
    end else begin
      i_imem_rvalid = 1'b0;
    end
    i_imem_rdata = $urandom;
    #1;

    if (rst) begin
      check_eq("rst_imem_valid", {31'b0, o_imem_valid}, 32'd0);
      check_eq("rst_valid", {31'b0, o_valid}, 32'd0);
      infl_q.delete();
      fifo_m.delete();
      m_pc = ResetPc;
    end else begin
      exp_iv = !redir && (infl_q.size() + fifo_m.size() < Depth);
      check_eq("imem_valid", {31'b0, o_imem_valid}, {31'b0, exp_iv});
      if (exp_iv) check_eq("imem_addr", o_imem_addr, m_pc);
      exp_v = (fifo_m.size() > 0) && !redir;
      check_eq("valid", {31'b0, o_valid}, {31'b0, exp_v});
      if (exp_v) begin
        check_eq("pc", o_pc, fifo_m[0].pc);
        check_eq("instr", o_instruction, fifo_m[0].instr);
      end
      if (exp_v && i_ready) void'(fifo_m.pop_front());
      if (i_imem_rvalid && infl_q.size() > 0) begin
        e = infl_q.pop_front();
        if (e.keep && !redir) fifo_m.push_back('{pc: e.pc, instr: i_imem_rdata});
      end
      if (redir) begin
        fifo_m.delete();
        foreach (infl_q[k]) infl_q[k].keep = 1'b0;
        m_pc = {rpc[31:2], 2'b00};
      end else if (exp_iv && i_imem_ready) begin
        infl_q.push_back('{pc: m_pc, keep: 1'b1});
        m_pc = m_pc + 32'd4;
      end
    end

    if (!rst && o_imem_valid && i_imem_ready) begin
      due = cyc + $urandom_range(max_lat, 1);
      if (due <= last_due) due = last_due + 1;
      mem_due.push_back(due);
      last_due = due;
    end
    prev_rst = rst;
    cyc++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 32'h0);
  endtask

  task automatic wait_inflight(input int unsigned want);
    for (int i = 0; i < 40 && infl_q.size() < want; i++) run_cycle(1'b0, 1'b0, 32'h0);
    check_eq("wait_inflight", {31'b0, infl_q.size() >= want}, 32'd1);
  endtask

  initial begin
    logic [31:0] rpc;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    last_due = 0;
    prev_rst = 1'b1;
    m_pc = ResetPc;
    i_rst = 1'b1;
    i_redirect = 1'b0;
    i_redirect_pc = '0;
    i_imem_ready = 1'b0;
    i_imem_rvalid = 1'b0;
    i_imem_rdata = '0;
    i_ready = 1'b0;
    ready_pct = 100;
    mready_mode = 0;
    max_lat = 1;

    for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 32'h0);
    run_n(30);

    // Decode stall: buffer fills, requests stop, head held.
    ready_pct = 0;
    run_n(5);
    ready_pct = 100;
    run_n(10);

    // Redirect with two requests in flight.
    max_lat = 3;
    wait_inflight(2);
    run_cycle(1'b0, 1'b1, 32'h100);
    run_n(15);

    // Misaligned redirect landing on a response beat.
    for (int i = 0; i < 40; i++) begin
      if (mem_due.size() > 0 && mem_due[0] <= cyc) break;
      run_cycle(1'b0, 1'b0, 32'h0);
    end
    run_cycle(1'b0, 1'b1, 32'h202);
    run_n(10);

    // Back-to-back redirects, then a target that wraps the address space.
    wait_inflight(2);
    run_cycle(1'b0, 1'b1, 32'h400);
    run_cycle(1'b0, 1'b1, 32'h800);
    run_n(5);
    run_cycle(1'b0, 1'b1, 32'hFFFF_FFF9);
    run_n(15);

    // Toggling memory ready.
    mready_mode = 1;
    max_lat = 2;
    run_n(40);

    // Reset with requests in flight.
    mready_mode = 0;
    max_lat = 3;
    wait_inflight(2);
    run_cycle(1'b1, 1'b0, 32'h0);
    run_cycle(1'b1, 1'b0, 32'h0);
    run_n(20);

    // Random soak.
    mready_mode = 2;
    ready_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) begin
        run_cycle(1'b1, 1'b0, 32'h0);
      end else if ($urandom_range(99) < 4) begin
        rpc = $urandom;
        if ($urandom_range(3) != 0) rpc = rpc & 32'h0000_FFFF;
        run_cycle(1'b0, 1'b1, rpc);
      end else begin
        run_cycle(1'b0, 1'b0, 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
